// File: rtl/fp16_accum_seq.sv
// Sequencer in front of a combinational FP16 add/sub unit: streams a burst of
// operands into the adder, accumulates its result and holds the final sum.
module fp16_accum_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             sub_mode,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [15:0]      add_a,
    output logic [15:0]      add_b,
    output logic             add_sub,
    input  logic [15:0]      add_out,
    output logic [15:0]      res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [15:0]      acc;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] len_q;
    logic             sub_q;

    logic             op_zero;
    logic             acc_zero;
    logic             last_beat;
    logic [15:0]      acc_next;

    // The adder always assumes a hidden leading 1, so zero operands bypass it.
    assign op_zero   = (in_data[14:0] == 15'd0);
    assign acc_zero  = (acc[14:0] == 15'd0);
    assign last_beat = (count_q == len_q - CNT_W'(1));
    assign acc_next  = op_zero  ? acc :
                       acc_zero ? {in_data[15] ^ sub_q, in_data[14:0]} :
                                  add_out;

    // Handshake flags decode straight from the state register.
    assign in_ready  = (state == ACCUM);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // res_data is the accumulator itself; it only changes on start or in ACCUM.
    assign res_data  = acc;
    assign count     = count_q;
    assign add_a     = acc;
    assign add_b     = in_data;
    assign add_sub   = sub_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= 16'h0000;
            count_q <= '0;
            len_q   <= '0;
            sub_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc     <= 16'h0000;
                        count_q <= '0;
                        len_q   <= len;
                        sub_q   <= sub_mode;
                        state   <= (len == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc     <= acc_next;
                        count_q <= count_q + CNT_W'(1);
                        if (last_beat) state <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
